// File: rtl/life_grid_engine.sv
// Game-of-Life grid (B3/S23). It serves per-pixel colour lookups and builds the
// next generation by scanning one cell per cycle, then publishes it in a single edge.
module life_grid_engine #(
    parameter int unsigned ROWS        = 15,
    parameter int unsigned COLS        = 20,
    parameter int unsigned SPRITE_LOG2 = 5,
    parameter bit          WRAP        = 1'b1,
    parameter logic [2:0]  ALIVE_RGB   = 3'b101,
    parameter logic [2:0]  DEAD_RGB    = 3'b000,
    parameter string       INIT_FILE   = "assets/initial_matrix.txt"
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [9:0]              i_x,
    input  logic [9:0]              i_y,
    input  logic                    i_step,
    input  logic                    i_wr_en,
    input  logic [$clog2(ROWS)-1:0] i_wr_row,
    input  logic [$clog2(COLS)-1:0] i_wr_col,
    input  logic                    i_wr_val,
    output logic [2:0]              o_rgb,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [15:0]             o_gen
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SWAP
    } state_t;

    state_t                     state;
    logic [RW-1:0]              scan_row;
    logic [CW-1:0]              scan_col;
    logic [ROWS-1:0][COLS-1:0]  cur;
    logic [ROWS-1:0][COLS-1:0]  nxt;

    logic                       last_row;
    logic                       last_col;
    logic [RW-1:0]              row_up;
    logic [RW-1:0]              row_dn;
    logic [CW-1:0]              col_lt;
    logic [CW-1:0]              col_rt;
    logic                       up_ok;
    logic                       dn_ok;
    logic                       lt_ok;
    logic                       rt_ok;
    logic [7:0]                 nbrs;
    logic [3:0]                 nbr_count;
    logic                       next_cell;
    logic                       wr_ok;
    logic [9:0]                 px_row;
    logic [9:0]                 px_col;
    logic                       px_alive;

    assign last_row = (32'(scan_row) == ROWS - 1);
    assign last_col = (32'(scan_col) == COLS - 1);
    assign wr_ok    = i_wr_en && (32'(i_wr_row) < ROWS) && (32'(i_wr_col) < COLS);

    // Neighbour indices wrap on the torus; the *_ok flags zero edge neighbours in bounded mode.
    always_comb begin
        row_up    = (scan_row == '0) ? RW'(ROWS - 1) : scan_row - 1'b1;
        row_dn    = last_row ? '0 : scan_row + 1'b1;
        col_lt    = (scan_col == '0) ? CW'(COLS - 1) : scan_col - 1'b1;
        col_rt    = last_col ? '0 : scan_col + 1'b1;
        up_ok     = WRAP || (scan_row != '0);
        dn_ok     = WRAP || !last_row;
        lt_ok     = WRAP || (scan_col != '0);
        rt_ok     = WRAP || !last_col;
        nbrs      = {up_ok & lt_ok & cur[row_up][col_lt],
                     up_ok         & cur[row_up][scan_col],
                     up_ok & rt_ok & cur[row_up][col_rt],
                     lt_ok         & cur[scan_row][col_lt],
                     rt_ok         & cur[scan_row][col_rt],
                     dn_ok & lt_ok & cur[row_dn][col_lt],
                     dn_ok         & cur[row_dn][scan_col],
                     dn_ok & rt_ok & cur[row_dn][col_rt]};
        nbr_count = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            nbr_count = nbr_count + {3'b000, nbrs[i]};
        end
        next_cell = (nbr_count == 4'd3) || (cur[scan_row][scan_col] && (nbr_count == 4'd2));
    end

    always_comb begin
        px_row   = i_y >> SPRITE_LOG2;
        px_col   = i_x >> SPRITE_LOG2;
        px_alive = (32'(px_row) < ROWS) && (32'(px_col) < COLS) &&
                   cur[px_row[RW-1:0]][px_col[CW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            scan_row <= '0;
            scan_col <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_gen    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_step) begin
                        state    <= SCAN;
                        scan_row <= '0;
                        scan_col <= '0;
                        o_busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last_col) begin
                        scan_col <= '0;
                        if (last_row) begin
                            state    <= SWAP;
                            scan_row <= '0;
                        end else begin
                            scan_row <= scan_row + 1'b1;
                        end
                    end else begin
                        scan_col <= scan_col + 1'b1;
                    end
                end
                SWAP: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    o_gen  <= o_gen + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grid storage is deliberately outside the reset domain: reset must not disturb it.
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: if (wr_ok) cur[i_wr_row][i_wr_col] <= i_wr_val;
            SCAN: nxt[scan_row][scan_col] <= next_cell;
            SWAP: cur <= nxt;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rgb <= DEAD_RGB;
        end else begin
            o_rgb <= px_alive ? ALIVE_RGB : DEAD_RGB;
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: a toroidal and a bounded instance share
// all inputs, and the grid is read back cell by cell through the pixel path.
module tb_life_grid_engine;

    localparam int ROWS = 15;
    localparam int COLS = 20;
    localparam int N    = ROWS * COLS;
    localparam logic [2:0] MAG = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step;
    logic        wr_en;
    logic        wr_val;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [3:0]  wr_row;
    logic [4:0]  wr_col;
    logic [2:0]  rgb_w, rgb_b;
    logic        busy_w, busy_b, done_w, done_b;
    logic [15:0] gen_w, gen_b;

    int checks = 0;
    int errors = 0;
    int eg     = 0;
    int lat;
    int lat2;
    int ndone;
    logic [N-1:0] gw, gb, ew, eb;

    always #5 clk = ~clk;

    life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b1)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(px), .i_y(py), .i_step(step),
        .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_val(wr_val),
        .o_rgb(rgb_w), .o_busy(busy_w), .o_done(done_w), .o_gen(gen_w)
    );

    life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .WRAP(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_x(px), .i_y(py), .i_step(step),
        .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_val(wr_val),
        .o_rgb(rgb_b), .o_busy(busy_b), .o_done(done_b), .o_gen(gen_b)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int at(input int r, input int c);
        return r * COLS + c;
    endfunction

    task automatic wr(input int r, input int c, input logic v);
        wr_en  = 1'b1;
        wr_row = 4'(r);
        wr_col = 5'(c);
        wr_val = v;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic clear_grid;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wr(r, c, 1'b0);
    endtask

    task automatic read_grid(output logic [N-1:0] g_w, output logic [N-1:0] g_b);
        g_w = '0;
        g_b = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                px = 10'(c * 32);
                py = 10'(r * 32);
                tick();
                g_w[at(r, c)] = (rgb_w == MAG);
                g_b[at(r, c)] = (rgb_b == MAG);
            end
        end
    endtask

    // Pulses i_step for one cycle and returns the edge count to o_done (-1 on timeout).
    task automatic pulse_and_wait(output int l);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("busy_after_sample", busy_w, 1'b1);
        l = -1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (done_w) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic do_step(input string tag);
        int l;
        eg++;
        pulse_and_wait(l);
        check({tag, "_latency"}, l, N + 1);
        check({tag, "_busy_low"}, busy_w, 1'b0);
        check({tag, "_done_b"}, done_b, 1'b1);
        check({tag, "_busy_b"}, busy_b, 1'b0);
        check({tag, "_gen_w"}, gen_w, eg);
        check({tag, "_gen_b"}, gen_b, eg);
        tick();
        check({tag, "_done_one_cycle"}, done_w, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b1;
        step   = 1'b0;
        wr_en  = 1'b0;
        wr_val = 1'b0;
        wr_row = '0;
        wr_col = '0;
        px     = '0;
        py     = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy_w, 1'b0);
        check("rst_done", done_w, 1'b0);
        check("rst_gen", gen_w, 16'd0);
        check("rst_rgb", rgb_w, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_grid();

        // Pixel map and write latency
        wr(3, 4, 1'b1);
        px = 10'd128; py = 10'd96;  tick(); check("pix_128_96", rgb_w, MAG);
        px = 10'd159; py = 10'd127; tick(); check("pix_159_127", rgb_w, MAG);
        px = 10'd160; py = 10'd96;  tick(); check("pix_160_96", rgb_w, 3'b000);
        px = 10'd128; py = 10'd95;  tick(); check("pix_128_95", rgb_w, 3'b000);
        px = 10'd639; py = 10'd479; tick(); check("pix_639_479_dead", rgb_w, 3'b000);
        wr(14, 19, 1'b1);
        check("wr_latency_k", rgb_w, 3'b000);
        tick();
        check("wr_latency_k1", rgb_w, MAG);
        check("pix_639_479_b", rgb_b, MAG);
        wr(14, 0, 1'b1);
        px = 10'd0; py = 10'd480; tick(); check("pix_row15", rgb_w, 3'b000);
        wr(15, 0, 1'b1);
        wr(0, 20, 1'b1);
        read_grid(gw, gb);
        ew = '0;
        ew[at(3, 4)] = 1'b1; ew[at(14, 19)] = 1'b1; ew[at(14, 0)] = 1'b1;
        check("oob_write_ignored", gw, ew);
        clear_grid();

        // Blinker in the interior, then two back-to-back generations
        wr(7, 9, 1'b1); wr(7, 10, 1'b1); wr(7, 11, 1'b1);
        do_step("blink1");
        read_grid(gw, gb);
        ew = '0;
        ew[at(6, 10)] = 1'b1; ew[at(7, 10)] = 1'b1; ew[at(8, 10)] = 1'b1;
        check("blink1_grid_w", gw, ew);
        check("blink1_grid_b", gb, ew);

        step = 1'b1;
        tick();
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (done_w) begin
                lat = k;
                break;
            end
        end
        check("b2b_first_latency", lat, N + 1);
        check("b2b_first_gen", gen_w, eg + 1);
        tick();
        step = 1'b0;
        check("b2b_retrigger_busy", busy_w, 1'b1);
        check("b2b_retrigger_done_low", done_w, 1'b0);
        lat2 = -1;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (done_w) begin
                lat2 = k;
                break;
            end
        end
        check("b2b_period", lat2 + 1, N + 2);
        eg += 2;
        check("b2b_gen", gen_w, eg);
        tick();
        read_grid(gw, gb);
        check("b2b_grid_w", gw, ew);
        check("b2b_grid_b", gb, ew);
        clear_grid();

        // Block still life at the origin
        wr(0, 0, 1'b1); wr(0, 1, 1'b1); wr(1, 0, 1'b1); wr(1, 1, 1'b1);
        do_step("block_a"); do_step("block_b"); do_step("block_c");
        read_grid(gw, gb);
        ew = '0;
        ew[at(0, 0)] = 1'b1; ew[at(0, 1)] = 1'b1; ew[at(1, 0)] = 1'b1; ew[at(1, 1)] = 1'b1;
        check("block_grid_w", gw, ew);
        check("block_grid_b", gb, ew);
        clear_grid();

        // Corner block: stable on the torus, isolated cells when bounded
        wr(0, 0, 1'b1); wr(0, 19, 1'b1); wr(14, 0, 1'b1); wr(14, 19, 1'b1);
        do_step("corner_a"); do_step("corner_b"); do_step("corner_c");
        read_grid(gw, gb);
        ew = '0;
        ew[at(0, 0)] = 1'b1; ew[at(0, 19)] = 1'b1; ew[at(14, 0)] = 1'b1; ew[at(14, 19)] = 1'b1;
        check("corner_grid_w", gw, ew);
        check("corner_grid_b", gb, '0);
        clear_grid();

        // Blinker on the top edge
        wr(0, 9, 1'b1); wr(0, 10, 1'b1); wr(0, 11, 1'b1);
        do_step("edge");
        read_grid(gw, gb);
        ew = '0;
        ew[at(14, 10)] = 1'b1; ew[at(0, 10)] = 1'b1; ew[at(1, 10)] = 1'b1;
        eb = '0;
        eb[at(0, 10)] = 1'b1; eb[at(1, 10)] = 1'b1;
        check("edge_grid_w", gw, ew);
        check("edge_grid_b", gb, eb);

        // Step and write while busy are dropped
        step = 1'b1;
        tick();
        step  = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int k = 1; k <= 320; k++) begin
            step   = (k == 50);
            wr_en  = (k == 60);
            wr_row = 4'd5;
            wr_col = 5'd5;
            wr_val = 1'b1;
            tick();
            if (done_w) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        step   = 1'b0;
        wr_en  = 1'b0;
        wr_val = 1'b0;
        eg++;
        check("busyrule_latency", lat, N + 1);
        check("busyrule_single_done", ndone, 1);
        check("busyrule_idle_after", busy_w, 1'b0);
        check("busyrule_gen", gen_w, eg);
        read_grid(gw, gb);
        ew = '0;
        ew[at(0, 9)] = 1'b1; ew[at(0, 10)] = 1'b1; ew[at(0, 11)] = 1'b1;
        check("busyrule_grid_w", gw, ew);
        check("busyrule_grid_b", gb, '0);

        // Reset in the middle of a scan
        px = 10'd320; py = 10'd0;
        tick();
        check("prestep_pixel", rgb_w, MAG);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (149) tick();
        check("tearfree_pixel", rgb_w, MAG);
        check("midscan_busy", busy_w, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_w, 1'b0);
        check("abort_gen", gen_w, 16'd0);
        check("abort_rgb", rgb_w, 3'b000);
        check("abort_busy_b", busy_b, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        eg = 0;
        read_grid(gw, gb);
        check("abort_grid_w", gw, ew);
        check("abort_grid_b", gb, '0);
        do_step("fresh");
        read_grid(gw, gb);
        ew = '0;
        ew[at(14, 10)] = 1'b1; ew[at(0, 10)] = 1'b1; ew[at(1, 10)] = 1'b1;
        check("fresh_grid_w", gw, ew);
        check("fresh_grid_b", gb, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
